mem_access_ctrl: RTL and testbench

//  Sequences every MEM-stage access on the IO bus: loads, word stores, and

---
 rtl/mem_access_ctrl_pkg.sv | 36 +++
 rtl/mem_access_ctrl_bus_wait_timer.sv | 30 +++
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage bus access controller: bus widths,
// DRAM_EX type bit positions, FSM state encoding and the alignment check.
package mem_access_ctrl_pkg;

    localparam int IO_BUS_WIDTH_ADDR = 32;
    localparam int IO_BUS_WIDTH_DATA = 32;

    // Default bus wait limit and the counter width that can hold it
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 8;

    // DRAM_EX_TYPE bit positions: {B, H}; neither set means a full word
    localparam int DRAM_EX_B = 1;
    localparam int DRAM_EX_H = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RMW_WR,
        ST_FIN
    } state_t;

    // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] addr_lo);
        if (typ[DRAM_EX_B]) begin
            return 1'b0;
        end
        if (typ[DRAM_EX_H]) begin
            return addr_lo[0];
        end
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_bus_wait_timer.sv
// Counts bus cycles spent waiting for bus_ack within one bus phase and flags
// the cycle in which the wait limit is reached.
module mem_access_ctrl_bus_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Wait counter: restarts on every phase change, advances while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry lands on the TIMEOUT-th unacknowledged cycle so the phase ends there
    assign expired = en & (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage bus access sequencer: loads, word stores and read-modify-write
// for byte/half stores, with pipeline stall, misalignment and timeout errors.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         req_we,
    input  logic [1:0]                   req_type,
    input  logic [IO_BUS_WIDTH_ADDR-1:0] req_addr,
    input  logic                         bus_ack,
    input  logic [IO_BUS_WIDTH_DATA-1:0] bus_rd,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [IO_BUS_WIDTH_DATA-1:0] bus_rd_WB,
    output logic [IO_BUS_WIDTH_DATA-1:0] rd_data,
    output logic                         stall,
    output logic                         done,
    output logic                         err
);

    state_t state;
    state_t state_nxt;
    logic   err_q;
    logic   err_nxt;
    logic   tmr_clr;
    logic   tmr_en;
    logic   tmr_expired;
    logic   sub_word;
    logic   addr_hi_unused;

    // Only the low address bits matter for alignment
    assign addr_hi_unused = ^req_addr[IO_BUS_WIDTH_ADDR-1:2];
    assign sub_word       = req_type[DRAM_EX_B] | req_type[DRAM_EX_H];

    // Bus strobes decode straight from the state register, so reset drops them at once
    assign bus_req = (state == ST_RD) || (state == ST_RMW_RD) ||
                     (state == ST_WR) || (state == ST_RMW_WR);
    assign bus_we  = (state == ST_WR) || (state == ST_RMW_WR);
    assign done    = (state == ST_FIN);
    assign err     = done & err_q;
    // Reset overrides the request so the pipeline is never held during reset
    assign stall   = req_valid & (state != ST_FIN) & ~rst;

    assign tmr_en  = bus_req & ~bus_ack;
    assign tmr_clr = (state_nxt != state);

    mem_access_ctrl_bus_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_bus_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State and error-flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    // Next-state: pick the access sequence in IDLE, advance phases on ack or timeout
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                err_nxt = 1'b0;
                if (req_valid) begin
                    if (is_misaligned(req_type, req_addr[1:0])) begin
                        state_nxt = ST_FIN;
                        err_nxt   = 1'b1;
                    end else if (!req_we) begin
                        state_nxt = ST_RD;
                    end else if (sub_word) begin
                        state_nxt = ST_RMW_RD;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_RD, ST_WR, ST_RMW_WR: begin
                if (bus_ack) begin
                    state_nxt = ST_FIN;
                end else if (tmr_expired) begin
                    state_nxt = ST_FIN;
                    err_nxt   = 1'b1;
                end
            end
            ST_RMW_RD: begin
                if (bus_ack) begin
                    state_nxt = ST_RMW_WR;
                end else if (tmr_expired) begin
                    // A timed-out old-word fetch must not be followed by a write
                    state_nxt = ST_FIN;
                    err_nxt   = 1'b1;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b0;
            end
        endcase
    end

    // Capture load data and the RMW old word only on ack in their own read phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            bus_rd_WB <= '0;
        end else begin
            if ((state == ST_RD) && bus_ack) begin
                rd_data <= bus_rd;
            end
            if ((state == ST_RMW_RD) && bus_ack) begin
                bus_rd_WB <= bus_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of accesses with per-access cycle counts,
// a scoreboard of expected done/err/data, plus reset and idle-ack sequences.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int AW = IO_BUS_WIDTH_ADDR;
    localparam int DW = IO_BUS_WIDTH_DATA;
    localparam logic [1:0] T_W = 2'b00;
    localparam logic [1:0] T_H = 2'b01;
    localparam logic [1:0] T_B = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_valid_t3;
    logic          req_we;
    logic [1:0]    req_type;
    logic [AW-1:0] req_addr;
    logic          bus_ack;
    logic [DW-1:0] bus_rd;

    logic          bus_req_m, bus_we_m, stall_m, done_m, err_m;
    logic [DW-1:0] wb_m, rdd_m;
    logic          bus_req_t, bus_we_t, stall_t, done_t, err_t;
    logic [DW-1:0] wb_t, rdd_t;

    bit            use_t3 = 1'b0;
    logic          o_bus_req, o_bus_we, o_stall, o_done, o_err;
    logic [DW-1:0] o_wb, o_rd;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .bus_ack   (bus_ack),
        .bus_rd    (bus_rd),
        .bus_req   (bus_req_m),
        .bus_we    (bus_we_m),
        .bus_rd_WB (wb_m),
        .rd_data   (rdd_m),
        .stall     (stall_m),
        .done      (done_m),
        .err       (err_m)
    );

    mem_access_ctrl #(.TIMEOUT(3), .CNT_W(2)) dut_t3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_t3),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .bus_ack   (bus_ack),
        .bus_rd    (bus_rd),
        .bus_req   (bus_req_t),
        .bus_we    (bus_we_t),
        .bus_rd_WB (wb_t),
        .rd_data   (rdd_t),
        .stall     (stall_t),
        .done      (done_t),
        .err       (err_t)
    );

    assign o_bus_req = use_t3 ? bus_req_t : bus_req_m;
    assign o_bus_we  = use_t3 ? bus_we_t  : bus_we_m;
    assign o_stall   = use_t3 ? stall_t   : stall_m;
    assign o_done    = use_t3 ? done_t    : done_m;
    assign o_err     = use_t3 ? err_t     : err_m;
    assign o_wb      = use_t3 ? wb_t      : wb_m;
    assign o_rd      = use_t3 ? rdd_t     : rdd_m;

    typedef struct {
        bit          t3;
        logic        we;
        logic [1:0]  typ;
        logic [31:0] addr;
        int          ack_dly;   // bus cycles before ack in each phase; -1 = never
        logic [31:0] rdata;
        logic        exp_err;
        int          exp_stall;
        int          exp_req;
        int          exp_we;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic [31:0] wb;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] m_rd[2];
    logic [31:0] m_wb[2];
    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vecs[11];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          n_stall = 0;
        int          n_req   = 0;
        int          n_we    = 0;
        int          phase   = 0;
        bit          got_done = 1'b0;
        bit          err_out  = 1'b0;
        bit          wb_seen  = 1'b0;
        logic [31:0] wb_at_wr = '0;
        sb_t         e;
        sb_t         a;
        int          idx;

        idx = v.t3 ? 1 : 0;
        if (!v.exp_err) begin
            if (!v.we) begin
                m_rd[idx] = v.rdata;
            end else if (v.typ != T_W) begin
                m_wb[idx] = v.rdata;
            end
        end
        e.err = v.exp_err;
        e.rd  = m_rd[idx];
        e.wb  = m_wb[idx];
        a.err = 1'b0;
        a.rd  = '0;
        a.wb  = '0;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        use_t3   = v.t3;
        req_we   = v.we;
        req_type = v.typ;
        req_addr = v.addr;
        bus_rd   = v.rdata;
        bus_ack  = 1'b0;
        if (v.t3) req_valid_t3 = 1'b1;
        else      req_valid    = 1'b1;

        for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
            @(negedge clk);
            if (o_stall) n_stall++;
            if (o_bus_we) begin
                n_we++;
                if (!wb_seen) begin
                    wb_seen  = 1'b1;
                    wb_at_wr = o_wb;
                end
            end
            if (o_done) begin
                got_done     = 1'b1;
                a.err        = o_err;
                a.rd         = o_rd;
                a.wb         = o_wb;
                req_valid    = 1'b0;
                req_valid_t3 = 1'b0;
                bus_ack      = 1'b0;
            end else begin
                if (o_err) err_out = 1'b1;
                if (o_bus_req) begin
                    n_req++;
                    if (v.ack_dly >= 0 && phase == v.ack_dly) begin
                        bus_ack = 1'b1;
                        phase   = 0;
                    end else begin
                        bus_ack = 1'b0;
                        phase++;
                    end
                end else begin
                    bus_ack = 1'b0;
                end
            end
        end

        check1({nm, ".done_seen"}, got_done, 1'b1);
        if (!got_done) begin
            req_valid    = 1'b0;
            req_valid_t3 = 1'b0;
            bus_ack      = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s.scoreboard: done with %0d entries queued, expected 1", nm, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            check1 ({nm, ".err"},       a.err, e.err);
            check32({nm, ".rd_data"},   a.rd,  e.rd);
            check32({nm, ".bus_rd_WB"}, a.wb,  e.wb);
        end
        check32({nm, ".stall_cycles"},  32'(n_stall), 32'(v.exp_stall));
        check32({nm, ".bus_req_cycles"}, 32'(n_req),  32'(v.exp_req));
        check32({nm, ".bus_we_cycles"},  32'(n_we),   32'(v.exp_we));
        check1 ({nm, ".err_outside_done"}, err_out, 1'b0);
        if (wb_seen && v.typ != T_W) begin
            check32({nm, ".old_word_at_write"}, wb_at_wr, v.rdata);
        end
        @(negedge clk);
        check1({nm, ".done_one_cycle"}, o_done, 1'b0);
        check1({nm, ".err_after_done"}, o_err,  1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           t3 we typ  addr          dly rdata         err stl req we
        vecs[0]  = '{0, 1, T_B, 32'h0000_0000, 0, 32'h0,        0,  0,  0,  0};
        vecs[0]  = '{0, 0, T_W, 32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 2, 1, 0};
        vecs[1]  = '{0, 1, T_B, 32'h0000_0103, 0, 32'h1122_3344, 0, 3, 2, 1};
        vecs[2]  = '{0, 1, T_W, 32'h0000_0200, 4, 32'h7777_7777, 0, 6, 5, 5};
        vecs[3]  = '{0, 0, T_H, 32'h0000_0101, 0, 32'h1234_5678, 1, 1, 0, 0};
        vecs[4]  = '{0, 0, T_W, 32'h0000_0102, 0, 32'h8765_4321, 1, 1, 0, 0};
        vecs[5]  = '{0, 0, T_B, 32'h0000_0103, 2, 32'hA5A5_0001, 0, 4, 3, 0};
        vecs[6]  = '{0, 1, T_H, 32'h0000_0206, 1, 32'hCAFE_F00D, 0, 5, 4, 2};
        vecs[7]  = '{0, 1, T_W, 32'h0000_0201, 0, 32'h0F0F_0F0F, 1, 1, 0, 0};
        vecs[8]  = '{1, 1, T_H, 32'h0000_0204, -1, 32'h5555_AAAA, 1, 4, 3, 0};
        vecs[9]  = '{1, 1, T_H, 32'h0000_0204, 2, 32'h3141_5926, 0, 7, 6, 3};
        vecs[10] = '{1, 0, T_W, 32'h0000_0300, 2, 32'h2718_2818, 0, 4, 3, 0};

        m_rd[0] = '0; m_rd[1] = '0;
        m_wb[0] = '0; m_wb[1] = '0;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_valid_t3 = 1'b0;
        req_we       = 1'b0;
        req_type     = T_W;
        req_addr     = '0;
        bus_ack      = 1'b0;
        bus_rd       = '0;

        repeat (2) @(posedge clk);
        #1;
        check1 ("reset.bus_req",   bus_req_m, 1'b0);
        check1 ("reset.bus_we",    bus_we_m,  1'b0);
        check1 ("reset.stall",     stall_m,   1'b0);
        check1 ("reset.done",      done_m,    1'b0);
        check1 ("reset.err",       err_m,     1'b0);
        check32("reset.rd_data",   rdd_m,     32'h0);
        check32("reset.bus_rd_WB", wb_m,      32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Ack while idle must be ignored: no activity and no data capture
        use_t3 = 1'b0;
        @(posedge clk);
        #1;
        bus_ack = 1'b1;
        bus_rd  = 32'hFFFF_FFFF;
        begin
            bit act = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done_m || bus_req_m || stall_m) act = 1'b1;
            end
            check1("idle_ack.no_activity", act, 1'b0);
        end
        check32("idle_ack.rd_data",   rdd_m, m_rd[0]);
        check32("idle_ack.bus_rd_WB", wb_m,  m_wb[0]);
        bus_ack = 1'b0;

        // Reset in the middle of the RMW write phase
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_type  = T_B;
        req_addr  = 32'h0000_0101;
        bus_rd    = 32'h5566_7788;
        req_valid = 1'b1;
        @(negedge clk);
        check1("rst_mid.idle_stall", stall_m, 1'b1);
        @(negedge clk);
        check1("rst_mid.rmw_rd_req", bus_req_m & ~bus_we_m, 1'b1);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check1("rst_mid.in_write", bus_we_m, 1'b1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check1 ("rst_mid.bus_req",   bus_req_m, 1'b0);
        check1 ("rst_mid.bus_we",    bus_we_m,  1'b0);
        check1 ("rst_mid.stall",     stall_m,   1'b0);
        check32("rst_mid.bus_rd_WB", wb_m,      32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0;
        m_wb[0] = '0; m_wb[1] = '0;
        begin
            bit act = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (bus_req_m || bus_we_m || done_m) act = 1'b1;
            end
            check1("rst_mid.no_resume", act, 1'b0);
        end
        run_vec('{0, 1, T_B, 32'h0000_0102, 0, 32'h99AA_BBCC, 0, 3, 2, 1}, "after_rst_sb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
